// File: rtl/bpsk_tx_scheduler_if.sv
// bpsk_tx_scheduler_if: two-requester packet handshake into the BPSK transmit scheduler
interface bpsk_tx_scheduler_if #(parameter int PACKET_SIZE = 16);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [PACKET_SIZE-1:0] req0_data, req1_data;
  modport master(output req0_valid, req0_data, req1_valid, req1_data, input req0_ready, req1_ready);
  modport slave(input req0_valid, req0_data, req1_valid, req1_data, output req0_ready, req1_ready);
endinterface

// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler: round-robin arbiter framing packets as preamble + sync + payload, one bit per symbol
module bpsk_tx_scheduler #(
  parameter int PACKET_SIZE = 16,
  parameter int SYMBOL_CYCLES = 64,
  parameter int PREAMBLE_BITS = 8,
  parameter logic [7:0] SYNC_WORD = 8'hD3,
  parameter int GAP_SYMBOLS = 2
) (
  input  logic clock,
  input  logic reset,
  bpsk_tx_scheduler_if.slave rq,
  output logic tx_bit,
  output logic tx_active,
  output logic symbol_strobe,
  output logic phase_reset,
  output logic tx_src,
  output logic tx_done
);
  localparam int SW = SYMBOL_CYCLES > 1 ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int M1 = PREAMBLE_BITS > 8 ? PREAMBLE_BITS : 8;
  localparam int M2 = PACKET_SIZE > M1 ? PACKET_SIZE : M1;
  localparam int MB = GAP_SYMBOLS > M2 ? GAP_SYMBOLS : M2;
  localparam int BW = $clog2(MB);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, GAP} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sym_cnt;
  logic [BW-1:0] bit_idx, bit_idx_nx, last_idx;
  logic [PACKET_SIZE-1:0] sh, sh_nx;
  logic rr_ptr, grant, accept, sym_end, last, bit_nx;
  always_comb begin
    grant = rq.req0_valid & rq.req1_valid ? rr_ptr : rq.req1_valid;
    accept = state == IDLE & (rq.req0_valid | rq.req1_valid);
    sym_end = sym_cnt == SW'(SYMBOL_CYCLES - 1);
    last_idx = state == PREAMBLE ? BW'(PREAMBLE_BITS - 1) :
               state == SYNC ? BW'(7) :
               state == PAYLOAD ? BW'(PACKET_SIZE - 1) : BW'(GAP_SYMBOLS - 1);
    last = sym_end & bit_idx == last_idx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      sym_cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      tx_bit <= 1'b0;
      tx_src <= 1'b0;
    end else begin
      state <= state_nx;
      sym_cnt <= state == IDLE || sym_end ? '0 : sym_cnt + 1'b1;
      bit_idx <= bit_idx_nx;
      sh <= sh_nx;
      tx_bit <= bit_nx;
      if (accept) begin
        rr_ptr <= ~grant;
        tx_src <= grant;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = PREAMBLE;
      PREAMBLE: if (last) state_nx = SYNC;
      SYNC:     if (last) state_nx = PAYLOAD;
      PAYLOAD:  if (last) state_nx = GAP_SYMBOLS > 0 ? GAP : IDLE;
      default:  if (last) state_nx = IDLE;
    endcase
    bit_idx_nx = state_nx != state ? '0 : sym_end ? bit_idx + 1'b1 : bit_idx;
    sh_nx = accept ? (grant ? rq.req1_data : rq.req0_data) :
            state == PAYLOAD && sym_end ? sh << 1 : sh;
    bit_nx = state_nx == PREAMBLE ? ~bit_idx_nx[0] :
             state_nx == SYNC ? SYNC_WORD[~bit_idx_nx[2:0]] :
             state_nx == PAYLOAD ? sh_nx[PACKET_SIZE-1] : 1'b0;
  end
  always_comb begin
    tx_active = state == PREAMBLE || state == SYNC || state == PAYLOAD;
    symbol_strobe = tx_active & sym_end;
    phase_reset = state == PREAMBLE && sym_cnt == '0 && bit_idx == '0;
    tx_done = state == PAYLOAD && last;
    rq.req0_ready = accept & ~grant;
    rq.req1_ready = accept & grant;
  end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// tb_bpsk_tx_scheduler: scoreboard bench for the BPSK transmit scheduler
module tb_bpsk_tx_scheduler;
  localparam int PS = 16, SC = 4, PB = 4, GS = 2, FB = PB + 8 + PS;
  localparam logic [7:0] SYNC = 8'hD3;
  typedef struct packed { logic b; logic s; logic d; } exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic tx_bit, tx_active, symbol_strobe, phase_reset, tx_src, tx_done;
  int vectors = 0, miscompares = 0;
  int n_strobe = 0, n_phase = 0, n_done = 0, n_active = 0;
  int act_base = 0, st_base = 0, ph_base = 0, dn_base = 0;
  bit mon_en = 1'b0;
  logic m_rr = 1'b0;
  time done_t = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  always #5 clock = ~clock;
  bpsk_tx_scheduler_if #(.PACKET_SIZE(PS)) rq();
  bpsk_tx_scheduler #(
    .PACKET_SIZE(PS), .SYMBOL_CYCLES(SC), .PREAMBLE_BITS(PB), .SYNC_WORD(SYNC), .GAP_SYMBOLS(GS)
  ) dut (
    .clock(clock), .reset(reset), .rq(rq), .tx_bit(tx_bit), .tx_active(tx_active),
    .symbol_strobe(symbol_strobe), .phase_reset(phase_reset), .tx_src(tx_src), .tx_done(tx_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic push_frame(input logic src, input logic [PS-1:0] d);
    logic [7:0] sw = SYNC;
    for (int i = 0; i < FB; i++) begin
      exp_t e;
      e.s = src;
      e.d = i == FB - 1;
      if (i < PB) e.b = (i % 2) == 0;
      else if (i < PB + 8) e.b = sw[7 - (i - PB)];
      else e.b = d[PS - 1 - (i - PB - 8)];
      exp_q.push_back(e);
    end
  endtask
  task automatic drive(input logic v0, input logic [PS-1:0] d0, input logic v1, input logic [PS-1:0] d1);
    @(posedge clock);
    #1;
    rq.req0_valid = v0;
    rq.req0_data = d0;
    rq.req1_valid = v1;
    rq.req1_data = d1;
  endtask
  task automatic take(input bit b2b, output int waited);
    logic src;
    int t = 0;
    @(negedge clock);
    while (!(rq.req0_ready || rq.req1_ready) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    waited = t;
    check("accept_in_time", 32'(t < 2000), 1);
    src = rq.req0_valid && rq.req1_valid ? m_rr : rq.req1_valid;
    check("req0_ready", rq.req0_ready, !src);
    check("req1_ready", rq.req1_ready, src);
    if (b2b) check("gap_cycles", 32'(($time - done_t) / 10), GS * SC + 1);
    push_frame(src, src ? rq.req1_data : rq.req0_data);
    m_rr = ~src;
    act_base = n_active;
    st_base = n_strobe;
    ph_base = n_phase;
    dn_base = n_done;
    @(negedge clock);
    check("ready_drop", {rq.req0_ready, rq.req1_ready}, 0);
    check("first_phase_reset", phase_reset, 1);
    check("first_active", tx_active, 1);
  endtask
  task automatic finish_frame();
    int t = 0;
    while ((exp_q.size() > 0 || tx_active) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("frame_end_in_time", 32'(t < 2000), 1);
    check("active_cycles", n_active - act_base, FB * SC);
    check("strobes", n_strobe - st_base, FB);
    check("phase_resets", n_phase - ph_base, 1);
    check("dones", n_done - dn_base, 1);
  endtask
  always @(negedge clock) begin
    if (mon_en) begin
      if (tx_active) begin
        n_active++;
        check("ready_busy", {rq.req0_ready, rq.req1_ready}, 0);
        if (exp_q.size() > 0) begin
          check("tx_bit", tx_bit, exp_q[0].b);
          check("tx_src", tx_src, exp_q[0].s);
        end
      end else begin
        check("quiet", {tx_bit, symbol_strobe, phase_reset, tx_done}, 0);
      end
      if (phase_reset) n_phase++;
      if (symbol_strobe) begin
        n_strobe++;
        if (exp_q.size() == 0) check("stray_strobe", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("tx_done_at_strobe", tx_done, mon_e.d);
        end
      end
      if (tx_done) begin
        n_done++;
        done_t = $time;
        check("done_cycle", n_active - act_base, FB * SC);
      end
    end
  end
  initial begin
    int w, t, dn;
    rq.req0_valid = 1'b0;
    rq.req1_valid = 1'b0;
    rq.req0_data = '0;
    rq.req1_data = '0;
    @(posedge clock);
    #1 mon_en = 1'b1;
    @(negedge clock);
    check("rst_outputs", {tx_bit, tx_active, symbol_strobe, phase_reset, tx_src, tx_done}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1, 16'hCAFE, 0, 0);
    take(0, w);
    check("t1_immediate", w, 0);
    drive(0, 0, 0, 0);
    finish_frame();
    @(posedge clock);
    #1 reset = 1'b1;
    rq.req0_valid = 1'b1;
    rq.req0_data = 16'h1234;
    rq.req1_valid = 1'b1;
    rq.req1_data = 16'hABCD;
    m_rr = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    take(0, w);
    check("t2_first_src", tx_src, 0);
    finish_frame();
    take(1, w);
    check("t2_second_src", tx_src, 1);
    finish_frame();
    take(1, w);
    check("t2_third_src", tx_src, 0);
    drive(0, 0, 0, 0);
    finish_frame();
    drive(0, 0, 1, 16'h5A5A);
    take(0, w);
    drive(0, 0, 0, 0);
    finish_frame();
    drive(1, 16'h0F0F, 1, 16'hF00F);
    take(0, w);
    check("t3_tie_to_req0", tx_src, 0);
    drive(0, 16'h0F0F, 0, 16'hF00F);
    t = 0;
    while (exp_q.size() > FB - PB && t < 500) begin
      @(posedge clock);
      #1 t++;
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      rq.req1_valid = ~rq.req1_valid;
      rq.req1_data = 16'($urandom);
    end
    drive(0, 0, 0, 0);
    finish_frame();
    drive(1, 16'h9E37, 0, 0);
    take(0, w);
    drive(0, 0, 0, 0);
    t = 0;
    while (exp_q.size() != PS - 5 && t < 500) begin
      @(posedge clock);
      #1 t++;
    end
    check("t5_reach_bit5", 32'(t < 500), 1);
    reset = 1'b1;
    rq.req1_valid = 1'b1;
    rq.req1_data = 16'h3C3C;
    dn = n_done;
    exp_q.delete();
    m_rr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t5_reset_outputs", {tx_bit, tx_active, symbol_strobe, phase_reset, tx_src, tx_done}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    check("t5_no_done", n_done - dn, 0);
    take(0, w);
    check("t5_first_idle_accept", w, 0);
    drive(0, 0, 0, 0);
    finish_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
